read_log_uart_tx: RTL and testbench

Logs completed master read transactions and streams them to a host over a UART line. Sits directly downstream of the bus top level: watches `m1_state`/`m2_state` and `m1_data_read`/`m2_data_read`, queues one record per completed read in a small FIFO, and serialises each record as two 8N1 UART frames. Provides board-level visibility of read results without a logic analyser.

---
 rtl/read_log_uart_tx.sv | 233 +++++++++++++++++++++++
 tb/tb_read_log_uart_tx.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/read_log_uart_tx.sv
//------------------------------------------------------------------------------
// read_log_uart_tx: queues one {src,data} record per completed master read and
// streams each record as a header byte plus a data byte over an 8N1 UART line.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module read_log_uart_tx #(
  parameter logic [4:0] READ_DONE_STATE = 5'd9,
  parameter int         DEPTH           = 8,
  parameter int         CLKS_PER_BIT    = 434
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [4:0]               m1_state,
  input  logic [4:0]               m2_state,
  input  logic [7:0]               m1_data_read,
  input  logic [7:0]               m2_data_read,
  output logic                     tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [7:0]               drop_count
);

  localparam int               AW         = $clog2(DEPTH);
  localparam int               CNT_W      = AW + 1;
  localparam int               CW         = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] C_FULL     = CNT_W'(DEPTH);
  localparam logic [CW-1:0]    C_BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [7:0]       C_HDR_M1   = 8'hA1;
  localparam logic [7:0]       C_HDR_M2   = 8'hA2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // Event detect and pending-record registers
  logic [4:0]       m1_prev_q, m1_prev_d;
  logic [4:0]       m2_prev_q, m2_prev_d;
  logic             pend_valid_q, pend_valid_d;
  logic [8:0]       pend_rec_q, pend_rec_d;

  // FIFO
  logic [8:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       drop_q, drop_d;

  // Transmitter
  state_t           state_q, state_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             second_q, second_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;

  logic             ev1, ev2;
  logic             wr_valid;
  logic [8:0]       wr_rec;
  logic             full, pop, push, drop;
  logic [8:0]       rd_rec;
  logic             bit_last;

  // Event detect, write arbitration and FIFO bookkeeping
  always_comb begin
    ev1          = (m1_state == READ_DONE_STATE) && (m1_prev_q != READ_DONE_STATE);
    ev2          = (m2_state == READ_DONE_STATE) && (m2_prev_q != READ_DONE_STATE);
    m1_prev_d    = m1_state;
    m2_prev_d    = m2_state;

    wr_valid     = 1'b0;
    wr_rec       = 9'd0;
    pend_valid_d = 1'b0;
    pend_rec_d   = pend_rec_q;
    // A deferred m2 record always goes first; any fresh event is deferred instead.
    if (pend_valid_q) begin
      wr_valid     = 1'b1;
      wr_rec       = pend_rec_q;
      pend_valid_d = ev1 | ev2;
      pend_rec_d   = ev1 ? {1'b0, m1_data_read} : {1'b1, m2_data_read};
    end else if (ev1) begin
      wr_valid     = 1'b1;
      wr_rec       = {1'b0, m1_data_read};
      pend_valid_d = ev2;
      pend_rec_d   = {1'b1, m2_data_read};
    end else if (ev2) begin
      wr_valid     = 1'b1;
      wr_rec       = {1'b1, m2_data_read};
    end

    full   = (count_q == C_FULL);
    pop    = (state_q == S_IDLE) && (count_q != '0);
    push   = wr_valid && (!full || pop);
    drop   = wr_valid && full && !pop;
    rd_rec = mem_q[rd_ptr_q];

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    drop_d = (drop && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
  end

  // Transmitter next-state: header frame, then data frame back to back
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    second_d  = second_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    bit_last  = (bit_cnt_q == C_BIT_LAST);

    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          data_d    = rd_rec[7:0];
          shift_d   = rd_rec[8] ? C_HDR_M2 : C_HDR_M1;
          second_d  = 1'b0;
          busy_d    = 1'b1;
          tx_d      = 1'b0;
          bit_cnt_d = '0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (bit_last) begin
          bit_cnt_d = '0;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
          state_d   = S_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (bit_last) begin
          bit_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (bit_last) begin
          bit_cnt_d = '0;
          if (!second_q) begin
            second_d = 1'b1;
            shift_d  = data_q;
            tx_d     = 1'b0;
            state_d  = S_START;
          end else begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_rec;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m1_prev_q    <= READ_DONE_STATE;
      m2_prev_q    <= READ_DONE_STATE;
      pend_valid_q <= 1'b0;
      pend_rec_q   <= 9'd0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      drop_q       <= 8'd0;
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'd0;
      data_q       <= 8'd0;
      second_q     <= 1'b0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      m1_prev_q    <= m1_prev_d;
      m2_prev_q    <= m2_prev_d;
      pend_valid_q <= pend_valid_d;
      pend_rec_q   <= pend_rec_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      drop_q       <= drop_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      second_q     <= second_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;
  assign drop_count = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_read_log_uart_tx.sv
//------------------------------------------------------------------------------
// tb_read_log_uart_tx: directed and random stimulus checked against a queue-based
// record model and a UART line decoder.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_read_log_uart_tx;

  localparam int         DEPTH   = 8;
  localparam int         CPB     = 4;
  localparam int         REC_CYC = 20 * CPB;
  localparam logic [4:0] RDS     = 5'd9;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] m1_state = 5'd0;
  logic [4:0] m2_state = 5'd0;
  logic [7:0] m1_data = 8'd0;
  logic [7:0] m2_data = 8'd0;
  logic       tx;
  logic       busy;
  logic [3:0] fifo_count;
  logic [7:0] drop_count;

  always #5 clk = ~clk;

  read_log_uart_tx #(
    .READ_DONE_STATE (RDS),
    .DEPTH           (DEPTH),
    .CLKS_PER_BIT    (CPB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .m1_state     (m1_state),
    .m2_state     (m2_state),
    .m1_data_read (m1_data),
    .m2_data_read (m2_data),
    .tx           (tx),
    .busy         (busy),
    .fifo_count   (fifo_count),
    .drop_count   (drop_count)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model: records waiting to be written, queued records, expected bytes
  logic [4:0] mp1, mp2;
  logic [8:0] arr[$];
  logic [8:0] fq[$];
  logic [7:0] exp_bytes[$];
  logic [7:0] rx_log[$];
  logic [7:0] want[$];
  int         drops;
  int         busy_left;

  bit         rx_active;
  int         rx_cnt;
  logic [7:0] rx_shift;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [8:0] r;
    if (reset) begin
      mp1 = RDS; mp2 = RDS;
      arr.delete(); fq.delete(); exp_bytes.delete();
      drops = 0; busy_left = 0;
    end else begin
      if (m1_state == RDS && mp1 != RDS) arr.push_back({1'b0, m1_data});
      if (m2_state == RDS && mp2 != RDS) arr.push_back({1'b1, m2_data});
      if (busy_left > 0) begin
        busy_left--;
      end else if (fq.size() > 0) begin
        r = fq.pop_front();
        exp_bytes.push_back(r[8] ? 8'hA2 : 8'hA1);
        exp_bytes.push_back(r[7:0]);
        busy_left = REC_CYC;
      end
      if (arr.size() > 0) begin
        r = arr.pop_front();
        if (fq.size() < DEPTH) fq.push_back(r);
        else if (drops < 255) drops++;
      end
      mp1 = m1_state; mp2 = m2_state;
    end
  endtask

  // UART decoder: samples mid-bit from the first low sample of a start bit
  task automatic rx_sample();
    int k;
    if (reset) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (tx === 1'b0) begin
        rx_active = 1'b1;
        rx_cnt    = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt == CPB / 2) begin
        check("rx_start_bit", tx, 0);
      end else if (rx_cnt > CPB / 2 && (rx_cnt - CPB / 2) % CPB == 0) begin
        k = (rx_cnt - CPB / 2) / CPB;
        if (k <= 8) begin
          rx_shift = {tx, rx_shift[7:1]};
        end else begin
          check("rx_stop_bit", tx, 1);
          rx_log.push_back(rx_shift);
          check("rx_byte_expected", exp_bytes.size() > 0, 1);
          if (exp_bytes.size() > 0) check("rx_byte", rx_shift, exp_bytes.pop_front());
          rx_active = 1'b0;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("fifo_count", fifo_count, fq.size());
    check("drop_count", drop_count, drops);
    check("busy", busy, busy_left > 0);
    if (busy_left == 0) check("tx_idle_high", tx, 1);
    rx_sample();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((busy_left > 0 || fq.size() > 0 || arr.size() > 0 || rx_active) && n < budget) begin
      step();
      n++;
    end
    check("drain_in_budget", n < budget, 1);
    repeat (3) step();
  endtask

  task automatic check_rx(input string tag);
    check({tag, "_len"}, rx_log.size(), want.size());
    for (int i = 0; i < want.size(); i++) begin
      if (i < rx_log.size()) check(tag, rx_log[i], want[i]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rx_active = 1'b0;
    rx_cnt    = 0;
    rx_shift  = 8'd0;

    // Reset with m1 already sitting in the read-done state
    reset = 1'b1; m1_state = RDS; m1_data = 8'hEE;
    repeat (3) step();
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_fifo_count", fifo_count, 0);
    check("reset_drop_count", drop_count, 0);
    reset = 1'b0;
    repeat (5) step();
    check("no_event_at_release", fifo_count, 0);
    check("no_tx_at_release", busy, 0);

    // Single m1 read held for 10 cycles
    m1_state = 5'd0;
    repeat (2) step();
    rx_log.delete();
    m1_state = RDS; m1_data = 8'h3C;
    step();
    check("single_count", fifo_count, 1);
    repeat (9) step();
    m1_state = 5'd0;
    drain(400);
    want.delete(); want.push_back(8'hA1); want.push_back(8'h3C);
    check_rx("single_rx");

    // Simultaneous m1/m2 while the transmitter is busy
    rx_log.delete();
    m1_state = RDS; m1_data = 8'h55;
    step();
    m1_state = 5'd0;
    repeat (2) step();
    m1_state = RDS; m1_data = 8'h11;
    m2_state = RDS; m2_data = 8'h22;
    step();
    check("simul_count1", fifo_count, 1);
    m1_state = 5'd0; m2_state = 5'd0;
    step();
    check("simul_count2", fifo_count, 2);
    drain(600);
    want.delete();
    want.push_back(8'hA1); want.push_back(8'h55);
    want.push_back(8'hA1); want.push_back(8'h11);
    want.push_back(8'hA2); want.push_back(8'h22);
    check_rx("simul_rx");

    // Overflow: 10 events while busy, then saturate the drop counter
    for (int i = 0; i < 10; i++) begin
      m1_state = RDS; m1_data = 8'($urandom);
      step();
      m1_state = 5'd0;
      step();
    end
    check("overflow_full", fifo_count, DEPTH);
    for (int i = 0; i < 260; i++) begin
      m1_state = RDS; m1_data = 8'($urandom);
      m2_state = RDS; m2_data = 8'($urandom);
      step();
      m1_state = 5'd0; m2_state = 5'd0;
      step();
    end
    check("drop_saturated", drop_count, 255);
    drain(2000);

    // Reset in the middle of the header byte's data bits
    m1_state = RDS; m1_data = 8'h5A;
    step();
    m1_state = 5'd0; m2_state = RDS; m2_data = 8'h77;
    step();
    m2_state = 5'd0;
    repeat (5) step();
    reset = 1'b1;
    step();
    check("midreset_tx", tx, 1);
    check("midreset_busy", busy, 0);
    check("midreset_fifo_count", fifo_count, 0);
    reset = 1'b0;
    step();
    rx_log.delete();
    m2_state = RDS; m2_data = 8'hC3;
    step();
    m2_state = 5'd0;
    drain(400);
    want.delete(); want.push_back(8'hA2); want.push_back(8'hC3);
    check_rx("after_reset_rx");

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      m1_state = ($urandom_range(0, 3) == 0) ? RDS : 5'($urandom_range(0, 31));
      m2_state = ($urandom_range(0, 3) == 0) ? RDS : 5'($urandom_range(0, 31));
      m1_data  = 8'($urandom);
      m2_data  = 8'($urandom);
      step();
    end
    m1_state = 5'd0; m2_state = 5'd0;
    drain(3000);
    check("all_bytes_received", exp_bytes.size(), 0);
    check("rx_idle_at_end", rx_active, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
